// File: rtl/axi_master_mux_pkg.sv
// Shared AXI constants and FSM state types for the AXI master front-end.
package axi_master_mux_pkg;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'd2;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/axi_master_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// which moves past the winner when the owning FSM accepts the grant.
module rr_arbiter #(
  parameter  int unsigned NUM_CH = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              adv,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search order wraps mod NUM_CH, so non-power-of-2 counts never visit invalid indices
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!gnt_any && req[IDX_W'((32'(ptr_q) + i) % NUM_CH)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'((32'(ptr_q) + i) % NUM_CH);
      end
    end
    gnt          = '0;
    gnt[gnt_idx] = gnt_any;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv && gnt_any) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_master_mux.sv
// AXI4 master front-end: arbitrates NUM_CH requestors onto one AXI port with
// independent round-robin read and write state machines.
module axi_master_mux
  import axi_master_mux_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 2,
  parameter  int unsigned ADDR_W  = 32,
  parameter  int unsigned DATA_W  = 64,
  parameter  int unsigned ID_W    = 2,
  parameter  int unsigned MAX_LEN = 15,
  localparam int unsigned STRB_W  = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        rd_req_in,
  input  logic [NUM_CH*ADDR_W-1:0] rd_addr_in,
  input  logic [NUM_CH*8-1:0]      rd_len_in,
  output logic [NUM_CH-1:0]        rd_gnt_out,
  output logic [DATA_W-1:0]        rd_data_out,
  output logic [NUM_CH-1:0]        rd_valid_out,
  output logic                     rd_last_out,
  output logic                     rd_err_out,
  input  logic [NUM_CH-1:0]        wr_req_in,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr_in,
  input  logic [NUM_CH*8-1:0]      wr_len_in,
  input  logic [NUM_CH*DATA_W-1:0] wr_data_in,
  input  logic [NUM_CH*STRB_W-1:0] wr_strb_in,
  input  logic [NUM_CH-1:0]        wr_dvalid_in,
  output logic [NUM_CH-1:0]        wr_dready_out,
  output logic [NUM_CH-1:0]        wr_done_out,
  output logic                     wr_err_out,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [ID_W-1:0]          arid,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [ID_W-1:0]          rid,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [ID_W-1:0]          awid,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_W-1:0]        wdata,
  output logic [STRB_W-1:0]        wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [ID_W-1:0]          bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [2:0]               arsize,
  output logic [2:0]               awsize,
  output logic [1:0]               arburst,
  output logic [1:0]               awburst,
  output logic [3:0]               arcache,
  output logic [3:0]               awcache,
  output logic [2:0]               prot,
  output logic [3:0]               qos,
  output logic                     lock,
  output logic                     user
);

  localparam int unsigned IDX_W     = $clog2(NUM_CH);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  assign arsize  = 3'($clog2(STRB_W));
  assign awsize  = 3'($clog2(STRB_W));
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign arcache = CACHE_DEFAULT;
  assign awcache = CACHE_DEFAULT;
  assign prot    = '0;
  assign qos     = '0;
  assign lock    = 1'b0;
  assign user    = 1'b0;

  // Only bit 1 of a response distinguishes an error
  logic unused_resp_lsb;
  assign unused_resp_lsb = rresp[0] ^ bresp[0];

  rd_state_e         rd_state_q, rd_state_d;
  logic [IDX_W-1:0]  rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic [NUM_CH-1:0] rd_gnt_vec;
  logic [IDX_W-1:0]  rd_gnt_idx;
  logic              rd_gnt_any, rd_adv;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rd_arb (
    .clk(clk), .rst_n(rstn), .req(rd_req_in), .adv(rd_adv),
    .gnt(rd_gnt_vec), .gnt_idx(rd_gnt_idx), .gnt_any(rd_gnt_any)
  );

  assign araddr = rd_addr_q;
  assign arlen  = rd_len_q;
  assign arid   = ID_W'(rd_owner_q);

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_owner_d   = rd_owner_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    rd_cnt_d     = rd_cnt_q;
    rd_adv       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    rd_gnt_out   = '0;
    rd_valid_out = '0;
    rd_data_out  = '0;
    rd_last_out  = 1'b0;
    rd_err_out   = 1'b0;
    case (rd_state_q)
      R_IDLE: if (rd_gnt_any) begin
        rd_adv     = 1'b1;
        rd_owner_d = rd_gnt_idx;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (rd_gnt_vec[i]) begin
            rd_addr_d = rd_addr_in[i*ADDR_W +: ADDR_W];
            rd_len_d  = clamp_len(rd_len_in[i*8 +: 8], MAX_LEN_B);
          end
        end
        rd_state_d = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          rd_gnt_out[rd_owner_q] = 1'b1;
          rd_cnt_d               = '0;
          rd_state_d             = R_DATA;
        end
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rd_valid_out[rd_owner_q] = 1'b1;
          rd_data_out              = rdata;
          rd_last_out              = rlast;
          // Beats past len keep flowing until rlast; each one is flagged
          rd_err_out = rresp[1] || (rid != ID_W'(rd_owner_q)) ||
                       (rlast != (rd_cnt_q == rd_len_q)) || (rd_cnt_q > rd_len_q);
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 8'd1;
          if (rlast) rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_q <= R_IDLE;
      rd_owner_q <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_owner_q <= rd_owner_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  wr_state_e         wr_state_q, wr_state_d;
  logic [IDX_W-1:0]  wr_owner_q, wr_owner_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic [NUM_CH-1:0] wr_gnt_vec;
  logic [IDX_W-1:0]  wr_gnt_idx;
  logic              wr_gnt_any, wr_adv;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_wr_arb (
    .clk(clk), .rst_n(rstn), .req(wr_req_in), .adv(wr_adv),
    .gnt(wr_gnt_vec), .gnt_idx(wr_gnt_idx), .gnt_any(wr_gnt_any)
  );

  assign awaddr = wr_addr_q;
  assign awlen  = wr_len_q;
  assign awid   = ID_W'(wr_owner_q);

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_owner_d    = wr_owner_q;
    wr_addr_d     = wr_addr_q;
    wr_len_d      = wr_len_q;
    wr_cnt_d      = wr_cnt_q;
    wr_adv        = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    wdata         = '0;
    wstrb         = '0;
    wlast         = 1'b0;
    bready        = 1'b0;
    wr_dready_out = '0;
    wr_done_out   = '0;
    wr_err_out    = 1'b0;
    case (wr_state_q)
      W_IDLE: if (wr_gnt_any) begin
        wr_adv     = 1'b1;
        wr_owner_d = wr_gnt_idx;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (wr_gnt_vec[i]) begin
            wr_addr_d = wr_addr_in[i*ADDR_W +: ADDR_W];
            wr_len_d  = clamp_len(wr_len_in[i*8 +: 8], MAX_LEN_B);
          end
        end
        wr_state_d = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) begin
          wr_cnt_d   = '0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wvalid = wr_dvalid_in[wr_owner_q];
        wdata  = wr_data_in[wr_owner_q*DATA_W +: DATA_W];
        wstrb  = wr_strb_in[wr_owner_q*STRB_W +: STRB_W];
        wlast  = (wr_cnt_q == wr_len_q);
        if (wvalid && wready) begin
          wr_dready_out[wr_owner_q] = 1'b1;
          wr_cnt_d                  = wr_cnt_q + 8'd1;
          if (wlast) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          wr_done_out[wr_owner_q] = 1'b1;
          wr_err_out              = bresp[1] || (bid != ID_W'(wr_owner_q));
          wr_state_d              = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= W_IDLE;
      wr_owner_q <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_owner_q <= wr_owner_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_master_mux.sv
// Self-checking bench for axi_master_mux: directed scenarios plus randomized
// traffic on both paths against a transaction-level reference model.
module tb_axi_master_mux;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    rd_req_in;
  logic [NCH*AW-1:0] rd_addr_in;
  logic [NCH*8-1:0]  rd_len_in;
  logic [NCH-1:0]    rd_gnt_out;
  logic [DW-1:0]     rd_data_out;
  logic [NCH-1:0]    rd_valid_out;
  logic              rd_last_out, rd_err_out;
  logic [NCH-1:0]    wr_req_in;
  logic [NCH*AW-1:0] wr_addr_in;
  logic [NCH*8-1:0]  wr_len_in;
  logic [NCH*DW-1:0] wr_data_in;
  logic [NCH*SW-1:0] wr_strb_in;
  logic [NCH-1:0]    wr_dvalid_in, wr_dready_out, wr_done_out;
  logic              wr_err_out;
  logic [AW-1:0]     araddr, awaddr;
  logic [7:0]        arlen, awlen;
  logic [1:0]        arid, awid, rid, bid, rresp, bresp;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]     rdata, wdata;
  logic [SW-1:0]     wstrb;
  logic [2:0]        arsize, awsize, prot;
  logic [1:0]        arburst, awburst;
  logic [3:0]        arcache, awcache, qos;
  logic              lock, user;

  axi_master_mux #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ID_W(2), .MAX_LEN(15)) dut (
    .clk(clk), .rstn(rstn),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_len_in(rd_len_in),
    .rd_gnt_out(rd_gnt_out), .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out),
    .rd_last_out(rd_last_out), .rd_err_out(rd_err_out),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_len_in(wr_len_in),
    .wr_data_in(wr_data_in), .wr_strb_in(wr_strb_in), .wr_dvalid_in(wr_dvalid_in),
    .wr_dready_out(wr_dready_out), .wr_done_out(wr_done_out), .wr_err_out(wr_err_out),
    .araddr(araddr), .arlen(arlen), .arid(arid), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awid(awid), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arsize(arsize), .awsize(awsize), .arburst(arburst), .awburst(awburst),
    .arcache(arcache), .awcache(awcache), .prot(prot), .qos(qos), .lock(lock), .user(user)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_ptr_m = 0;
  int wr_ptr_m = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration rule: first requester at or after the pointer
  function automatic int pick(input logic [NCH-1:0] req, input int ptr);
    for (int k = 0; k < NCH; k++) begin
      if (req[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  function automatic int clampl(input logic [7:0] len);
    return (len > 8'd15) ? 15 : int'(len);
  endfunction

  // Serves one read from the AR handshake to the idle cycle after rlast.
  // Entered just before the negedge at which arvalid must be visible.
  task automatic serve_read(input int ch, input logic [31:0] addr, input logic [7:0] len,
                            input int ar_dly, input int nbeats, input bit gapped,
                            input logic [1:0] resp, input bit bad_id, input bit drop,
                            input int abort_at, input logic [63:0] seed);
    int L;
    logic [63:0] d;
    bit last, exp_err;
    L = clampl(len);
    for (int k = 0; k <= ar_dly; k++) begin
      @(negedge clk); arready = (k == ar_dly); #1;
      check("arvalid", arvalid, 1);
      check("araddr", araddr, addr);
      check("arlen", arlen, L);
      check("arid", arid, ch);
      check("rd_gnt", rd_gnt_out, (k == ar_dly) ? (2'b1 << ch) : 2'b0);
    end
    @(negedge clk); arready = 0; if (drop) rd_req_in[ch] = 0; #1;
    check("rready_data", rready, 1);
    check("rd_gnt_after", rd_gnt_out, 0);
    for (int b = 0; b < nbeats; b++) begin
      if (gapped || $urandom_range(0, 3) == 0) begin
        @(negedge clk); rvalid = 0; #1;
        check("rd_valid_gap", rd_valid_out, 0);
      end
      @(negedge clk);
      d    = (seed != 0) ? seed + 64'(b) : {$urandom, $urandom};
      last = (b == nbeats - 1);
      rvalid = 1; rdata = d; rresp = resp; rlast = last;
      rid = bad_id ? (2'(ch) ^ 2'b01) : 2'(ch);
      if (b == abort_at) begin
        rstn = 0; #1;
        check("rst_rd_valid", rd_valid_out, 0);
        check("rst_rd_data", rd_data_out, 0);
        check("rst_rd_flags", {rd_last_out, rd_err_out, rready, arvalid}, 0);
        check("rst_wr_flags", {awvalid, wvalid, bready, wr_done_out, wr_err_out}, 0);
        check("rst_araddr", araddr, 0);
        rvalid = 0; rlast = 0;
        rd_ptr_m = 0; wr_ptr_m = 0;
        return;
      end
      #1;
      exp_err = resp[1] || bad_id || (last != (b == L)) || (b > L);
      check("rd_valid", rd_valid_out, 2'b1 << ch);
      check("rd_data", rd_data_out, d);
      check("rd_last", rd_last_out, last);
      check("rd_err", rd_err_out, exp_err);
    end
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    check("rready_idle", rready, 0);
    check("arvalid_idle", arvalid, 0);
  endtask

  // Serves one write from AW through the B handshake; drops the request after done.
  task automatic serve_write(input int ch, input logic [31:0] addr, input logic [7:0] len,
                             input logic [7:0] strb, input int aw_dly, input int stall_after,
                             input int stall_n, input logic [1:0] resp, input bit bad_id);
    int L;
    logic [63:0] d;
    L = clampl(len);
    for (int k = 0; k <= aw_dly; k++) begin
      @(negedge clk); awready = (k == aw_dly); wr_dvalid_in[ch] = 1; #1;
      check("awvalid", awvalid, 1);
      check("awaddr", awaddr, addr);
      check("awlen", awlen, L);
      check("awid", awid, ch);
      check("wvalid_before_aw", wvalid, 0);
    end
    for (int b = 0; b <= L; b++) begin
      if (b == stall_after) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk); awready = 0; wr_dvalid_in[ch] = 0; wready = 1; #1;
          check("wvalid_stall", wvalid, 0);
          check("wr_dready_stall", wr_dready_out, 0);
        end
      end
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); awready = 0; wr_dvalid_in[ch] = 1; wready = 0;
        wr_data_in[ch*DW +: DW] = d; #1;
        check("wvalid_bp", wvalid, 1);
        check("wr_dready_bp", wr_dready_out, 0);
      end
      @(negedge clk);
      awready = 0; wready = 1; wr_dvalid_in[ch] = 1;
      wr_data_in[ch*DW +: DW] = d;
      wr_strb_in[ch*SW +: SW] = strb;
      wr_data_in[(1-ch)*DW +: DW] = {$urandom, $urandom};
      wr_strb_in[(1-ch)*SW +: SW] = 8'($urandom);
      wr_dvalid_in[1-ch] = 1'($urandom_range(0, 1));
      #1;
      check("wvalid", wvalid, 1);
      check("wdata", wdata, d);
      check("wstrb", wstrb, strb);
      check("wlast", wlast, (b == L));
      check("wr_dready", wr_dready_out, 2'b1 << ch);
      check("awvalid_data", awvalid, 0);
    end
    for (int k = 0; k <= int'($urandom_range(0, 2)); k++) begin
      @(negedge clk); wready = 0; wr_dvalid_in[ch] = 0; #1;
      check("bready", bready, 1);
      check("wvalid_resp", wvalid, 0);
      check("wr_done_wait", wr_done_out, 0);
    end
    @(negedge clk);
    bvalid = 1; bresp = resp; bid = bad_id ? (2'(ch) ^ 2'b01) : 2'(ch); #1;
    check("wr_done", wr_done_out, 2'b1 << ch);
    check("wr_err", wr_err_out, resp[1] || bad_id);
    @(negedge clk); bvalid = 0; wr_req_in[ch] = 0; #1;
    check("bready_idle", bready, 0);
    check("wr_done_idle", wr_done_out, 0);
  endtask

  task automatic read_loop(input int n);
    logic [NCH-1:0] held;
    logic [31:0] a [NCH];
    logic [7:0]  l [NCH];
    int ch, nb;
    held = '0;
    for (int it = 0; it < n; it++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!held[c] && ($urandom_range(0, 1) == 1 || (held == 0 && c == NCH - 1))) begin
          held[c] = 1;
          a[c] = $urandom;
          l[c] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 4));
          rd_addr_in[c*AW +: AW] = a[c];
          rd_len_in[c*8 +: 8] = l[c];
          rd_req_in[c] = 1;
        end
      end
      ch = pick(held, rd_ptr_m);
      rd_ptr_m = (ch + 1) % NCH;
      nb = clampl(l[ch]) + 1;
      case ($urandom_range(0, 7))
        0: nb = nb + 1;
        1: if (nb > 1) nb = nb - 1;
        default: ;
      endcase
      serve_read(ch, a[ch], l[ch], $urandom_range(0, 2), nb, 0,
                 ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, ($urandom_range(0, 7) == 0), 1, -1, 0);
      held[ch] = 0;
    end
  endtask

  task automatic write_loop(input int n);
    logic [NCH-1:0] held;
    logic [31:0] a [NCH];
    logic [7:0]  l [NCH];
    int ch;
    held = '0;
    for (int it = 0; it < n; it++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!held[c] && ($urandom_range(0, 1) == 1 || (held == 0 && c == 0))) begin
          held[c] = 1;
          a[c] = $urandom;
          l[c] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 4));
          wr_addr_in[c*AW +: AW] = a[c];
          wr_len_in[c*8 +: 8] = l[c];
          wr_req_in[c] = 1;
        end
      end
      ch = pick(held, wr_ptr_m);
      wr_ptr_m = (ch + 1) % NCH;
      serve_write(ch, a[ch], l[ch], 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                  ($urandom_range(0, 7) == 0));
      held[ch] = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    rstn = 0;
    rd_req_in = '0; rd_addr_in = '0; rd_len_in = '0;
    wr_req_in = '0; wr_addr_in = '0; wr_len_in = '0;
    wr_data_in = '0; wr_strb_in = '0; wr_dvalid_in = '0;
    arready = 0; awready = 0; wready = 0;
    rdata = '0; rid = '0; rresp = '0; rlast = 0; rvalid = 0;
    bid = '0; bresp = '0; bvalid = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valids", {arvalid, awvalid, rready, bready, wvalid, wlast}, 0);
    check("rst_pulses", {rd_gnt_out, wr_done_out, rd_valid_out, wr_dready_out}, 0);
    check("rst_errs", {rd_err_out, wr_err_out, rd_last_out}, 0);
    check("rst_addr_len", {araddr, awaddr, arlen, awlen}, 0);
    check("const_size", {arsize, awsize}, {3'd3, 3'd3});
    check("const_burst_cache", {arburst, awburst, arcache, awcache}, {2'b01, 2'b01, 4'd2, 4'd2});
    check("const_misc", {prot, qos, lock, user}, 0);
    @(negedge clk); rstn = 1;

    // Single read, ch1, len 0, arready after 2 cycles
    @(negedge clk);
    rd_req_in[1] = 1; rd_addr_in[AW +: AW] = 32'h8000_0040; rd_len_in[8 +: 8] = 8'd0;
    ch = pick(2'b10, rd_ptr_m); rd_ptr_m = (ch + 1) % NCH;
    serve_read(ch, 32'h8000_0040, 8'd0, 2, 1, 0, 2'b00, 0, 1, -1, 64'hDEAD_BEEF_0000_0001);

    // Burst read, ch0, len 15, gapped every other cycle
    rd_req_in[0] = 1; rd_addr_in[0 +: AW] = 32'h0000_1000; rd_len_in[0 +: 8] = 8'd15;
    ch = pick(2'b01, rd_ptr_m); rd_ptr_m = (ch + 1) % NCH;
    serve_read(ch, 32'h0000_1000, 8'd15, 0, 16, 1, 2'b00, 0, 1, -1, 0);

    // Both channels held, len 0: grants must alternate
    rd_req_in = 2'b11; rd_len_in = '0;
    rd_addr_in = {32'h2000_0100, 32'h1000_0100};
    for (int i = 0; i < 4; i++) begin
      ch = pick(rd_req_in, rd_ptr_m); rd_ptr_m = (ch + 1) % NCH;
      serve_read(ch, rd_addr_in[ch*AW +: AW], 8'd0, $urandom_range(0, 1), 1, 0, 2'b00, 0, (i >= 2), -1, 0);
    end

    // Write ch1, len 3, strb 0F, stall after beat 2 for 3 cycles, SLVERR
    wr_req_in[1] = 1; wr_addr_in[AW +: AW] = 32'h4000_0080; wr_len_in[8 +: 8] = 8'd3;
    ch = pick(2'b10, wr_ptr_m); wr_ptr_m = (ch + 1) % NCH;
    serve_write(ch, 32'h4000_0080, 8'd3, 8'h0F, 1, 2, 3, 2'b10, 0);

    // Read ch0 and write ch1 issued in the same cycle
    rd_req_in[0] = 1; rd_addr_in[0 +: AW] = 32'h0000_2000; rd_len_in[0 +: 8] = 8'd3;
    wr_req_in[1] = 1; wr_addr_in[AW +: AW] = 32'h0000_3000; wr_len_in[8 +: 8] = 8'd2;
    rd_ptr_m = (pick(2'b01, rd_ptr_m) + 1) % NCH;
    wr_ptr_m = (pick(2'b10, wr_ptr_m) + 1) % NCH;
    fork
      serve_read(0, 32'h0000_2000, 8'd3, 0, 4, 0, 2'b00, 0, 1, -1, 0);
      serve_write(1, 32'h0000_3000, 8'd2, 8'hFF, 0, 9, 0, 2'b00, 0);
    join

    // Reset during beat 5 of a 16-beat read on ch0
    rd_req_in[0] = 1; rd_addr_in[0 +: AW] = 32'h0000_5000; rd_len_in[0 +: 8] = 8'd15;
    ch = pick(2'b01, rd_ptr_m);
    serve_read(ch, 32'h0000_5000, 8'd15, 0, 16, 0, 2'b00, 0, 1, 4, 0);
    @(negedge clk); rstn = 1; #1;
    check("post_rst_idle", {rready, arvalid, rd_valid_out}, 0);
    rd_req_in[1] = 1; rd_addr_in[AW +: AW] = 32'h0000_6000; rd_len_in[8 +: 8] = 8'd1;
    ch = pick(rd_req_in, rd_ptr_m); rd_ptr_m = (ch + 1) % NCH;
    serve_read(ch, 32'h0000_6000, 8'd1, 0, 2, 0, 2'b00, 0, 1, -1, 0);

    // Pointer returns to channel 0 after a reset taken while idle
    rd_req_in[0] = 1; rd_addr_in[0 +: AW] = 32'h0000_7000; rd_len_in[0 +: 8] = 8'd0;
    ch = pick(rd_req_in, rd_ptr_m); rd_ptr_m = (ch + 1) % NCH;
    serve_read(ch, 32'h0000_7000, 8'd0, 0, 1, 0, 2'b00, 0, 1, -1, 0);
    rstn = 0; rd_ptr_m = 0; wr_ptr_m = 0;
    @(negedge clk); rstn = 1;
    rd_req_in = 2'b11;
    rd_addr_in = {32'h0000_8100, 32'h0000_8000}; rd_len_in = '0;
    for (int i = 0; i < 2; i++) begin
      ch = pick(rd_req_in, rd_ptr_m); rd_ptr_m = (ch + 1) % NCH;
      serve_read(ch, rd_addr_in[ch*AW +: AW], 8'd0, 0, 1, 0, 2'b00, 0, 1, -1, 0);
    end

    // Randomized concurrent traffic on both paths
    fork
      read_loop(14);
      write_loop(14);
    join

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
